rangefinder_sample_capture: RTL and testbench
=============================================

RANGEFINDER_SAMPLE_CAPTURE -- requirements
Module: rangefinder_sample_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width in bits (1..32).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning log2 of buffer depth (DEPTH = 2^ADDR_W).
REQ-003 SHALL have parameter PRETRIG_RST, default 32, meaning reset value of the PRETRIG register.
REQ-004 SHALL have ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  input sample strobe.
- st_data  in  DATA_W  input sample.
- trig_in  in  1  trigger qualifier, sampled with st_valid.
- avs_address  in  ADDR_W+1  MSB=1 selects CSR space, MSB=0 selects sample memory.
- avs_read  in  1  Avalon read.
- avs_write  in  1  Avalon write, CSR space only.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency 1.
- irq  out  1  level interrupt.

Function
REQ-005 SHALL implement FSM states IDLE, PREFILL, ARMED, POST, DONE.
REQ-006 SHALL store each st_valid sample at wr_ptr and increment wr_ptr modulo DEPTH in PREFILL, ARMED and POST only.
REQ-007 SHALL, on a CONTROL.ARM write in any state, clear wr_ptr, pre_cnt, post_cnt and DONE, and enter PREFILL.
REQ-008 SHALL go PREFILL->ARMED once PRETRIG samples are stored, or immediately when PRETRIG=0.
REQ-009 SHALL ignore trig_in in PREFILL.
REQ-010 SHALL, in ARMED with st_valid&trig_in, store the sample, latch its address into TRIG_PTR, count it as post-sample 1, and enter POST.
REQ-011 SHALL go POST->DONE when DEPTH-PRETRIG post-samples are stored, so the buffer holds exactly DEPTH samples with the oldest at address (TRIG_PTR-PRETRIG) mod DEPTH.
REQ-012 SHALL, when PRETRIG = DEPTH-1 and a trigger occurs, go directly from ARMED to DONE after storing the single post-sample.
REQ-013 SHALL, on a CONTROL.ABORT write, return to IDLE with DONE=0; when ARM and ABORT are written together, ABORT wins.
REQ-014 SHALL clamp PRETRIG writes to DEPTH-1, and apply a new value only at the next ARM.
REQ-015 SHALL use CSR map word 0 CONTROL (write: bit0 ARM, bit1 ABORT, bit2 IRQ_EN; read: bit0 BUSY, bit1 DONE, bit2 IRQ_EN), word 1 TRIG_PTR (read-only), word 2 PRETRIG (read/write); other CSR words read 0.
REQ-016 SHALL, on a memory read, return the sample zero-extended to 32 bits one cycle after avs_read; memory data read while BUSY is not guaranteed coherent.
REQ-017 SHALL, on a read in the same cycle as a write to the same address, return old data.
REQ-018 SHALL drive irq = DONE & IRQ_EN, with DONE cleared only by ARM, ABORT or reset.

Reset
REQ-019 SHALL, while reset_n=0, force: state IDLE; wr_ptr, counters and TRIG_PTR 0; PRETRIG=PRETRIG_RST clamped to DEPTH-1; IRQ_EN 0; avs_readdata 0; irq 0.
REQ-020 SHALL, on reset asserted mid-capture, abandon the capture; RAM contents are not cleared.

Structure
REQ-021 SHALL place the CSR word offsets, CONTROL/STATUS bit positions and the FSM state encoding in the shared package rangefinder_pkg.
REQ-022 SHALL instantiate one sub-module, rangefinder_sample_dpram (simple dual-port: 1 write port, 1 registered read port, old-data read-during-write), inferable as block RAM.

Verification
REQ-023 SHALL verify: defaults, ARM, 32 samples, then trigger on sample value 0xA5 at wr_ptr 0x20 -> TRIG_PTR=0x20, DONE after 224 more valid cycles counting the trigger sample, address 0x20 reads 0x000000A5.
REQ-024 SHALL verify: trig_in asserted during PREFILL sample 10 -> ignored, state remains PREFILL until sample 32.
REQ-025 SHALL verify: PRETRIG written 300 with ADDR_W=8 -> readback 255; trigger -> DONE after exactly 1 post-sample.
REQ-026 SHALL verify: IRQ_EN=1, capture completes -> irq=1; ARM|ABORT written together -> state IDLE, irq=0, BUSY=0.
REQ-027 SHALL verify: 600 valid samples in ARMED without trigger -> wr_ptr wraps twice, no DONE; trigger then gives oldest sample at (TRIG_PTR-32) mod 256.
REQ-028 SHALL verify: reset_n pulsed low during POST -> all outputs at reset values, state IDLE, STATUS reads 0.

Source files
------------

// File: rtl/rangefinder_pkg.sv
// Shared constants for the rangefinder sample capture block: CSR map, control/status bits
// and the capture FSM encoding.
package rangefinder_pkg;

    localparam int unsigned CsrControl = 0;
    localparam int unsigned CsrTrigPtr = 1;
    localparam int unsigned CsrPretrig = 2;

    localparam int unsigned CtrlArm   = 0;
    localparam int unsigned CtrlAbort = 1;
    localparam int unsigned CtrlIrqEn = 2;

    localparam int unsigned StatBusy  = 0;
    localparam int unsigned StatDone  = 1;
    localparam int unsigned StatIrqEn = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } cap_state_e;

endpackage

// File: rtl/rangefinder_sample_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port, old data returned
// on a same-address read-during-write.
module rangefinder_sample_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rangefinder_sample_capture.sv
// Pre/post-trigger sample capture into a circular buffer with an Avalon-MM CSR/memory port
// and a level interrupt on capture completion.
module rangefinder_sample_capture
    import rangefinder_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned PRETRIG_RST = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    input  logic [DATA_W-1:0] st_data,
    input  logic              trig_in,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);

    localparam int unsigned Depth       = 2**ADDR_W;
    localparam int unsigned PretrigInit = (PRETRIG_RST > Depth - 1) ? Depth - 1 : PRETRIG_RST;

    cap_state_e state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] pretrig_q, pretrig_act_q, pretrig_wdata;
    logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W:0]   post_target;
    logic              irq_en_q;
    logic              rd_q, csr_rd_q;
    logic [31:0]       csr_rdata_q, csr_rdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              csr_sel, ctrl_wr, pretrig_wr, arm, abort;
    logic              busy, done, store;
    logic [ADDR_W-1:0] csr_word;

    assign csr_sel    = avs_address[ADDR_W];
    assign csr_word   = avs_address[ADDR_W-1:0];
    assign ctrl_wr    = avs_write && csr_sel && (csr_word == ADDR_W'(CsrControl));
    assign pretrig_wr = avs_write && csr_sel && (csr_word == ADDR_W'(CsrPretrig));
    assign arm        = ctrl_wr && avs_writedata[CtrlArm];
    assign abort      = ctrl_wr && avs_writedata[CtrlAbort];

    assign busy  = (state_q == StPrefill) || (state_q == StArmed) || (state_q == StPost);
    assign done  = (state_q == StDone);
    // A control write in the same cycle as a sample takes priority; the sample is dropped.
    assign store = st_valid && busy && !arm && !abort;
    assign irq   = done && irq_en_q;

    assign pretrig_wdata = (avs_writedata > 32'(Depth - 1)) ? ADDR_W'(Depth - 1)
                                                            : avs_writedata[ADDR_W-1:0];
    // Post-samples needed (trigger included) so the buffer ends up holding exactly Depth samples.
    assign post_target   = (ADDR_W+1)'(Depth) - {1'b0, pretrig_act_q};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        trig_ptr_d = trig_ptr_q;
        if (abort) begin
            state_d = StIdle;
        end else if (arm) begin
            state_d    = StPrefill;
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            unique case (state_q)
                StPrefill: begin
                    if (pretrig_act_q == '0) begin
                        state_d = StArmed;
                    end else if (st_valid) begin
                        pre_cnt_d = pre_cnt_q + (ADDR_W+1)'(1);
                        if (pre_cnt_d == {1'b0, pretrig_act_q}) state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (st_valid && trig_in) begin
                        trig_ptr_d = wr_ptr_q;
                        post_cnt_d = (ADDR_W+1)'(1);
                        state_d    = (post_target == (ADDR_W+1)'(1)) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (st_valid) begin
                        post_cnt_d = post_cnt_q + (ADDR_W+1)'(1);
                        if (post_cnt_d == post_target) state_d = StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_word == ADDR_W'(CsrControl)) begin
            csr_rdata[StatBusy]  = busy;
            csr_rdata[StatDone]  = done;
            csr_rdata[StatIrqEn] = irq_en_q;
        end else if (csr_word == ADDR_W'(CsrTrigPtr)) begin
            csr_rdata = 32'(trig_ptr_q);
        end else if (csr_word == ADDR_W'(CsrPretrig)) begin
            csr_rdata = 32'(pretrig_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
            trig_ptr_q    <= '0;
            pretrig_q     <= ADDR_W'(PretrigInit);
            pretrig_act_q <= ADDR_W'(PretrigInit);
            irq_en_q      <= 1'b0;
            rd_q          <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_rdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            trig_ptr_q <= trig_ptr_d;
            if (ctrl_wr) irq_en_q <= avs_writedata[CtrlIrqEn];
            if (pretrig_wr) pretrig_q <= pretrig_wdata;
            if (arm && !abort) pretrig_act_q <= pretrig_q;
            rd_q        <= avs_read;
            csr_rd_q    <= csr_sel;
            csr_rdata_q <= csr_rdata;
        end
    end

    // RAM output is not resettable, so the read mux is qualified by a resettable read flag.
    assign avs_readdata = !rd_q    ? 32'd0 :
                          csr_rd_q ? csr_rdata_q : 32'(ram_rdata);

    rangefinder_sample_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata (st_data),
        .re    (avs_read && !csr_sel),
        .raddr (csr_word),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Randomized scoreboard bench for rangefinder_sample_capture with a stream-level capture model.
module tb_rangefinder_sample_capture;

    localparam int DEPTH = 256;
    localparam logic [8:0] A_CTRL = 9'h100;
    localparam logic [8:0] A_TP   = 9'h101;
    localparam logic [8:0] A_PT   = 9'h102;
    localparam logic [8:0] A_UN   = 9'h103;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [7:0]  st_data = '0;
    logic        trig_in = 1'b0;
    logic [8:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    always #5 clk = ~clk;

    rangefinder_sample_capture #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .PRETRIG_RST (32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .st_valid      (st_valid),
        .st_data       (st_data),
        .trig_in       (trig_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    // Capture model: samples are numbered from 0 after ARM; sample k lands at k mod DEPTH.
    int   m_cnt, m_trig, m_p, m_preg, m_tp;
    bit   m_active, m_done, m_irq_en;
    logic [7:0] ref_mem [DEPTH];
    bit         ref_known [DEPTH];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] exp_status();
        return {29'd0, m_irq_en, m_done, m_active};
    endfunction

    // Monitor: every read accepted at a clock edge is answered on the following half cycle.
    initial begin
        string       nm;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            if (avs_read) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_read: got 0x%08h, expected no response", avs_readdata);
                end else begin
                    nm = name_q.pop_front();
                    e  = exp_q.pop_front();
                    check(nm, avs_readdata, e);
                end
            end
        end
    end

    task automatic rd(input logic [8:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    task automatic wr(input logic [8:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
        if (addr == A_CTRL) begin
            m_irq_en = data[2];
            if (data[1]) begin
                m_active = 0;
                m_done   = 0;
            end else if (data[0]) begin
                m_active = 1;
                m_done   = 0;
                m_cnt    = 0;
                m_trig   = -1;
                m_p      = m_preg;
            end
        end else if (addr == A_PT) begin
            m_preg = (data > 32'(DEPTH - 1)) ? DEPTH - 1 : int'(data);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit t);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        st_valid = 1'b1;
        st_data  = d;
        trig_in  = t;
        @(negedge clk);
        st_valid = 1'b0;
        trig_in  = 1'b0;
        if (m_active) begin
            ref_mem[m_cnt % DEPTH]   = d;
            ref_known[m_cnt % DEPTH] = 1;
            if (m_trig < 0 && m_cnt >= m_p && t) begin
                m_trig = m_cnt;
                m_tp   = m_cnt % DEPTH;
            end
            m_cnt++;
            if (m_trig >= 0 && m_cnt == m_trig + DEPTH - m_p) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    task automatic send_n(input int n, input bit allow_trig);
        for (int i = 0; i < n; i++) send(8'($urandom), allow_trig && ($urandom_range(0, 3) == 0));
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < DEPTH; a++)
            if (ref_known[a]) rd(9'(a), 32'(ref_mem[a]), name);
    endtask

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_irq_en = 0;
        m_preg   = 32;
        m_tp     = 0;
        m_cnt    = 0;
        m_trig   = -1;
        m_p      = 32;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        for (int a = 0; a < DEPTH; a++) ref_known[a] = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Defaults after reset
        check("reset_irq", {31'd0, irq}, 32'd0);
        rd(A_CTRL, 32'd0, "reset_status");
        rd(A_TP, 32'd0, "reset_trig_ptr");
        rd(A_PT, 32'd32, "reset_pretrig");
        rd(A_UN, 32'd0, "unused_csr");

        // Basic capture; triggers during prefill (samples 10 and 32) must be ignored
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 32; i++) send(8'($urandom), (i == 9) || (i == 31));
        rd(A_CTRL, exp_status(), "prefill_busy");
        send(8'hA5, 1'b1);
        send_n(222, 1);
        rd(A_CTRL, exp_status(), "post_busy_before_last");
        send(8'($urandom), 1'b1);
        rd(A_CTRL, 32'h2, "done_status");
        rd(A_TP, 32'h20, "trig_ptr_0x20");
        rd(9'h020, 32'hA5, "trig_sample_a5");
        sweep("mem_capture_a");
        send_n(4, 1);
        rd(A_CTRL, exp_status(), "done_hold");
        rd(9'h020, 32'hA5, "no_store_after_done");

        // Interrupt and ARM|ABORT priority
        wr(A_CTRL, 32'h5);
        send_n(32, 1);
        send_n($urandom_range(0, 40), 0);
        send(8'($urandom), 1'b1);
        send_n(223, 1);
        check("irq_done", {31'd0, irq}, 32'd1);
        rd(A_CTRL, 32'h6, "done_irq_status");
        rd(A_TP, 32'(m_tp), "trig_ptr_b");
        wr(A_CTRL, 32'h7);
        check("irq_after_abort", {31'd0, irq}, 32'd0);
        rd(A_CTRL, 32'h4, "arm_abort_idle");

        // Pretrig clamp to DEPTH-1: single post-sample completes the capture
        wr(A_PT, 32'd300);
        rd(A_PT, 32'd255, "pretrig_clamp");
        wr(A_CTRL, 32'h1);
        send_n(255, 1);
        rd(A_CTRL, exp_status(), "pretrig255_busy");
        send(8'($urandom), 1'b1);
        rd(A_CTRL, 32'h2, "pretrig255_done");
        rd(A_TP, 32'(m_tp), "trig_ptr_c");
        sweep("mem_capture_c");

        // Long armed period: pointer wraps twice before the trigger
        wr(A_PT, 32'd32);
        wr(A_CTRL, 32'h1);
        send_n(32, 1);
        send_n(600, 0);
        rd(A_CTRL, 32'h1, "armed_no_done");
        send(8'($urandom), 1'b1);
        send_n(223, 1);
        rd(A_CTRL, 32'h2, "wrap_done");
        rd(A_TP, 32'd120, "wrap_trig_ptr");
        rd(9'((120 - 32) % DEPTH), 32'(ref_mem[(m_trig - 32) % DEPTH]), "wrap_oldest");
        sweep("mem_capture_d");

        // Reset in the middle of the post-trigger phase
        wr(A_CTRL, 32'h5);
        send_n(32, 0);
        send(8'($urandom), 1'b1);
        send_n(50, 1);
        rd(A_CTRL, exp_status(), "post_before_reset");
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_irq", {31'd0, irq}, 32'd0);
        check("reset_mid_readdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        rd(A_CTRL, 32'd0, "post_reset_status");
        rd(A_TP, 32'd0, "post_reset_trig_ptr");
        rd(A_PT, 32'd32, "post_reset_pretrig");
        sweep("mem_retained");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
